// File: rtl/axil_dmem_responder_if.sv
// AXI4-Lite bus bundle between the CPU memory initiator and the data-memory responder.
interface axil_dmem_responder_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_dmem_responder.sv
// AXI4-Lite data-memory responder: word array with byte strobes, independent
// read/write channels, configurable wait states, OKAY/SLVERR responses.
module axil_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    axil_dmem_responder_if.slave bus
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  RESP_OK   = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b10;
    localparam bit          NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

    logic [31:0] mem [DEPTH_WORDS];

    wstate_t     wstate;
    logic [3:0]  wcnt;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;
    logic [29:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    rstate_t     rstate;
    logic [3:0]  rcnt;
    logic        arready_q, rvalid_q;
    logic [1:0]  rresp_q;
    logic [29:0] araddr_q;
    logic [31:0] rdata_q;

    logic          aw_have_c, w_have_c, wr_commit_c, wr_inrange_c;
    logic [29:0]   wr_word_c;
    logic [31:0]   wr_data_c;
    logic [3:0]    wr_strb_c;
    logic [AW-1:0] wr_idx_c;
    logic          rd_sample_c, rd_inrange_c;
    logic [29:0]   rd_word_c;
    logic [AW-1:0] rd_idx_c;
    logic          unused_c;

    assign unused_c = ^{bus.awaddr[1:0], bus.araddr[1:0]};

    // A ready that is still high means that half has not been captured yet,
    // so the live bus value is the one that will be committed this cycle.
    always_comb begin
        aw_have_c    = !awready_q || bus.awvalid;
        w_have_c     = !wready_q || bus.wvalid;
        wr_word_c    = awready_q ? bus.awaddr[31:2] : awaddr_q;
        wr_data_c    = wready_q ? bus.wdata : wdata_q;
        wr_strb_c    = wready_q ? bus.wstrb : wstrb_q;
        wr_idx_c     = wr_word_c[AW-1:0];
        wr_inrange_c = ((wr_word_c >> AW) == 30'd0);
        wr_commit_c  = !reset &&
                       (((wstate == W_IDLE) && aw_have_c && w_have_c && NO_WAIT) ||
                        ((wstate == W_WAIT) && (wcnt == 4'd0)));

        rd_word_c    = (rstate == R_IDLE) ? bus.araddr[31:2] : araddr_q;
        rd_idx_c     = rd_word_c[AW-1:0];
        rd_inrange_c = ((rd_word_c >> AW) == 30'd0);
        rd_sample_c  = ((rstate == R_IDLE) && bus.arvalid && arready_q && NO_WAIT) ||
                       ((rstate == R_WAIT) && (rcnt == 4'd0));
    end

    // Write channel: capture AW and W independently, wait, commit, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate    <= W_IDLE;
            wcnt      <= 4'd0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OK;
            awaddr_q  <= 30'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (bus.awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        awaddr_q  <= bus.awaddr[31:2];
                    end
                    if (bus.wvalid && wready_q) begin
                        wready_q <= 1'b0;
                        wdata_q  <= bus.wdata;
                        wstrb_q  <= bus.wstrb;
                    end
                    if (aw_have_c && w_have_c) begin
                        wstate <= NO_WAIT ? W_RESP : W_WAIT;
                        wcnt   <= WAIT_LOAD;
                    end
                end
                W_WAIT: begin
                    if (wcnt == 4'd0) wstate <= W_RESP;
                    else              wcnt   <= wcnt - 4'd1;
                end
                W_RESP: begin
                    if (bus.bready) begin
                        wstate    <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
            if (wr_commit_c) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_inrange_c ? RESP_OK : RESP_ERR;
            end
        end
    end

    // Byte-lane array update; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (wr_commit_c && wr_inrange_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_c[b]) mem[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
            end
        end
    end

    // Read channel: a same-edge write commit is not yet visible here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate    <= R_IDLE;
            rcnt      <= 4'd0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OK;
            rdata_q   <= 32'd0;
            araddr_q  <= 30'd0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (bus.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        araddr_q  <= bus.araddr[31:2];
                        rstate    <= NO_WAIT ? R_RESP : R_WAIT;
                        rcnt      <= WAIT_LOAD;
                    end
                end
                R_WAIT: begin
                    if (rcnt == 4'd0) rstate <= R_RESP;
                    else              rcnt   <= rcnt - 4'd1;
                end
                R_RESP: begin
                    if (bus.rready) begin
                        rstate    <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
            if (rd_sample_c) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_inrange_c ? RESP_OK : RESP_ERR;
                rdata_q  <= rd_inrange_c ? mem[rd_idx_c] : 32'd0;
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_axil_dmem_responder.sv
// Directed bench: one responder with no wait states, one with three.
module tb_axil_dmem_responder;
    logic clk = 1'b0;
    logic rst0, rst3;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    axil_dmem_responder_if i0 ();
    axil_dmem_responder_if i3 ();

    axil_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(rst0), .bus(i0.slave));
    axil_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(rst3), .bus(i3.slave));

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int guard = 0;
        i0.awaddr = a; i0.awvalid = 1'b1; i0.wdata = d; i0.wstrb = s; i0.wvalid = 1'b1;
        while (!(aw_done && w_done) && guard < 20) begin
            aw_hs = i0.awvalid && i0.awready;
            w_hs  = i0.wvalid && i0.wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; i0.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  i0.wvalid  = 1'b0; end
            guard++;
        end
        i0.awvalid = 1'b0; i0.wvalid = 1'b0;
        lat = 1;
        while (!i0.bvalid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!(aw_done && w_done)) lat = 99;
        resp = i0.bresp;
        i0.bready = 1'b1; @(posedge clk); #1; i0.bready = 1'b0;
    endtask

    task automatic rd0(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp, output int lat);
        int guard = 0;
        bit done = 0;
        i0.araddr = a; i0.arvalid = 1'b1;
        while (!done && guard < 20) begin
            done = i0.arready;
            @(posedge clk); #1;
            guard++;
        end
        i0.arvalid = 1'b0;
        lat = 1;
        while (!i0.rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!done) lat = 99;
        data = i0.rdata; resp = i0.rresp;
        i0.rready = 1'b1; @(posedge clk); #1; i0.rready = 1'b0;
    endtask

    task automatic wr3(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int guard = 0;
        i3.awaddr = a; i3.awvalid = 1'b1; i3.wdata = d; i3.wstrb = s; i3.wvalid = 1'b1;
        while (!(aw_done && w_done) && guard < 20) begin
            aw_hs = i3.awvalid && i3.awready;
            w_hs  = i3.wvalid && i3.wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; i3.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  i3.wvalid  = 1'b0; end
            guard++;
        end
        i3.awvalid = 1'b0; i3.wvalid = 1'b0;
        lat = 1;
        while (!i3.bvalid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!(aw_done && w_done)) lat = 99;
        resp = i3.bresp;
        i3.bready = 1'b1; @(posedge clk); #1; i3.bready = 1'b0;
    endtask

    task automatic rd3(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp, output int lat);
        int guard = 0;
        bit done = 0;
        i3.araddr = a; i3.arvalid = 1'b1;
        while (!done && guard < 20) begin
            done = i3.arready;
            @(posedge clk); #1;
            guard++;
        end
        i3.arvalid = 1'b0;
        lat = 1;
        while (!i3.rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!done) lat = 99;
        data = i3.rdata; resp = i3.rresp;
        i3.rready = 1'b1; @(posedge clk); #1; i3.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat, bl, rl;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'h0, 2'b00, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[11] = '{1'b1, 32'h0000_0013, 32'h0102_0304, 4'h8, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'h01AD_BEEF};
        vecs[13] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
        vecs[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};

        i0.awaddr = '0; i0.awvalid = 0; i0.wdata = '0; i0.wstrb = '0; i0.wvalid = 0;
        i0.bready = 0; i0.araddr = '0; i0.arvalid = 0; i0.rready = 0;
        i3.awaddr = '0; i3.awvalid = 0; i3.wdata = '0; i3.wstrb = '0; i3.wvalid = 0;
        i3.bready = 0; i3.araddr = '0; i3.arvalid = 0; i3.rready = 0;
        rst0 = 1'b0; rst3 = 1'b0;
        #1; rst0 = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst0 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;

        check("reset readies",  32'({i0.awready, i0.wready, i0.arready}), 32'h7);
        check("reset valids",   32'({i0.bvalid, i0.rvalid}), 32'h0);
        check("reset resps",    32'({i0.bresp, i0.rresp}), 32'h0);
        check("reset rdata",    i0.rdata, 32'h0);
        check("reset3 readies", 32'({i3.awready, i3.wready, i3.arready, i3.bvalid, i3.rvalid}), 32'h1C);

        // Table vectors on the zero-wait responder
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wr0(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
                check($sformatf("v%0d bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d blat", i), 32'(lat), 32'd1);
            end else begin
                rd0(vecs[i].addr, data, resp, lat);
                check($sformatf("v%0d rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d rdata", i), data, vecs[i].exp_rdata);
                check($sformatf("v%0d rlat", i), 32'(lat), 32'd1);
            end
            check($sformatf("v%0d readies", i), 32'({i0.awready, i0.wready, i0.arready}), 32'h7);
        end

        // W leads AW by three cycles, then B is back-pressured
        i0.wdata = 32'h0BAD_F00D; i0.wstrb = 4'hF; i0.wvalid = 1'b1;
        @(posedge clk); #1; i0.wvalid = 1'b0;
        check("dec wready low", 32'({i0.awready, i0.wready, i0.bvalid}), 32'h4);
        repeat (2) begin
            @(posedge clk); #1;
            check("dec hold", 32'({i0.awready, i0.wready, i0.bvalid}), 32'h4);
        end
        i0.awaddr = 32'h30; i0.awvalid = 1'b1;
        @(posedge clk); #1; i0.awvalid = 1'b0;
        check("dec bvalid", 32'({i0.awready, i0.wready, i0.bvalid, i0.bresp}), 32'h4);
        repeat (4) begin
            @(posedge clk); #1;
            check("bp bvalid held", 32'({i0.awready, i0.wready, i0.bvalid, i0.bresp}), 32'h4);
        end
        i0.bready = 1'b1; @(posedge clk); #1; i0.bready = 1'b0;
        check("bp readies back", 32'({i0.awready, i0.wready, i0.bvalid}), 32'h6);
        rd0(32'h30, data, resp, lat);
        check("dec readback", data, 32'h0BAD_F00D);

        // Wait states: plain write, then simultaneous write and read to one word
        wr3(32'h40, 32'h5, 4'hF, resp, lat);
        check("w3 bresp", 32'(resp), 32'h0);
        check("w3 blat", 32'(lat), 32'd4);
        i3.awaddr = 32'h40; i3.awvalid = 1'b1; i3.wdata = 32'h9; i3.wstrb = 4'hF; i3.wvalid = 1'b1;
        i3.araddr = 32'h40; i3.arvalid = 1'b1;
        @(posedge clk); #1;
        i3.awvalid = 1'b0; i3.wvalid = 1'b0; i3.arvalid = 1'b0;
        bl = 0; rl = 0;
        for (int c = 1; c <= 10; c++) begin
            if (i3.bvalid && bl == 0) bl = c;
            if (i3.rvalid && rl == 0) rl = c;
            if (bl != 0 && rl != 0) break;
            @(posedge clk); #1;
        end
        check("col blat", 32'(bl), 32'd4);
        check("col rlat", 32'(rl), 32'd4);
        check("col rdata old", i3.rdata, 32'h5);
        check("col resps", 32'({i3.bresp, i3.rresp}), 32'h0);
        i3.bready = 1'b1; i3.rready = 1'b1;
        @(posedge clk); #1;
        i3.bready = 1'b0; i3.rready = 1'b0;
        check("col readies", 32'({i3.awready, i3.wready, i3.arready, i3.bvalid, i3.rvalid}), 32'h1C);
        rd3(32'h40, data, resp, lat);
        check("col later read", data, 32'h9);
        check("col later rlat", 32'(lat), 32'd4);

        // Reset while the write sits in W_WAIT
        wr3(32'h44, 32'h77, 4'hF, resp, lat);
        i3.awaddr = 32'h44; i3.awvalid = 1'b1; i3.wdata = 32'h88; i3.wstrb = 4'hF; i3.wvalid = 1'b1;
        @(posedge clk); #1;
        i3.awvalid = 1'b0; i3.wvalid = 1'b0;
        check("rst captured", 32'({i3.awready, i3.wready, i3.bvalid}), 32'h0);
        @(posedge clk); #1;
        rst3 = 1'b1; #1;
        check("rst async", 32'({i3.awready, i3.wready, i3.arready, i3.bvalid, i3.rvalid}), 32'h1C);
        @(posedge clk); #1; rst3 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst no bvalid", 32'({i3.awready, i3.wready, i3.arready, i3.bvalid, i3.rvalid}), 32'h1C);
        rd3(32'h44, data, resp, lat);
        check("rst word kept", data, 32'h77);
        check("rst rresp", 32'(resp), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
